bus_arbiter: RTL and testbench

// Round-robin arbiter sequencing ownership of one shared WIDTH-bit wired bus.
// The bus is tri-state with a pullup, so an undriven bus floats high.

---
 rtl/bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for a pulled-up shared bus: one grant at a time,
// a released turnaround gap between owners, and a bounded tenure under contention.
module bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 9,
    parameter int MAX_HOLD   = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic                    bus_oe,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    preempt,
    input  logic [WIDTH-1:0]        bus_in,
    output logic                    park_err
);
    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [TW-1:0] TURN_LEN = TW'(TURNAROUND);
    localparam logic [OW-1:0] RR_INIT  = OW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [OW-1:0]   rr_r;
    logic [HW-1:0]   hold_cnt_r;
    logic [TW-1:0]   tcnt_r;
    logic [NREQ-1:0] gnt_r;
    logic            bus_oe_r;
    logic [OW-1:0]   owner_r;
    logic            busy_r;
    logic            preempt_r;
    logic            park_err_r;
    logic            idle_seen_r;

    logic            pick_found_s;
    logic [OW-1:0]   pick_idx_s;
    logic [OW-1:0]   cand_s;
    logic            owner_req_s;
    logic            others_s;
    logic            hold_at_max_s;

    // A parked bus must read back as the pullup value on every bit.
    function automatic logic parked_ok_f(input logic [WIDTH-1:0] v);
        return &v;
    endfunction

    function automatic logic [NREQ-1:0] onehot_f(input logic [OW-1:0] idx);
        return NREQ'(1'b1) << idx;
    endfunction

    // Round-robin pick: first asserted request searching upward from rr+1.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {OW{1'b0}};
        cand_s       = {OW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = OW'((int'(rr_r) + k) % NREQ);
            if (!pick_found_s && req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Contention terms seen by the current owner.
    always_comb begin
        owner_req_s   = req[owner_r];
        others_s      = |(req & ~gnt_r);
        hold_at_max_s = (hold_cnt_r == HOLD_MAX);
    end

    // Ownership state machine; all bus-facing outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_r       <= RR_INIT;
            hold_cnt_r <= {HW{1'b0}};
            tcnt_r     <= {TW{1'b0}};
            gnt_r      <= {NREQ{1'b0}};
            bus_oe_r   <= 1'b0;
            owner_r    <= {OW{1'b0}};
            busy_r     <= 1'b0;
            preempt_r  <= 1'b0;
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r    <= ST_GRANT;
                        gnt_r      <= onehot_f(pick_idx_s);
                        bus_oe_r   <= 1'b1;
                        owner_r    <= pick_idx_s;
                        rr_r       <= pick_idx_s;
                        hold_cnt_r <= HW'(1'b1);
                        busy_r     <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A voluntary drop wins over a simultaneous hold-limit revoke.
                    if (!owner_req_s) begin
                        state_r  <= ST_TURN;
                        gnt_r    <= {NREQ{1'b0}};
                        bus_oe_r <= 1'b0;
                        tcnt_r   <= TURN_LEN;
                        busy_r   <= 1'b1;
                    end else if (others_s && hold_at_max_s) begin
                        state_r   <= ST_TURN;
                        gnt_r     <= {NREQ{1'b0}};
                        bus_oe_r  <= 1'b0;
                        tcnt_r    <= TURN_LEN;
                        busy_r    <= 1'b1;
                        preempt_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b1;
                        if (!hold_at_max_s) begin
                            hold_cnt_r <= hold_cnt_r + HW'(1'b1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                end
                ST_TURN: begin
                    if (tcnt_r <= TW'(1'b1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        tcnt_r <= tcnt_r - TW'(1'b1);
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    gnt_r    <= {NREQ{1'b0}};
                    bus_oe_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Sticky parked-bus check; the first idle cycle is skipped so a late release can settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_seen_r <= 1'b0;
            park_err_r  <= 1'b0;
        end else begin
            idle_seen_r <= (state_r == ST_IDLE);
            if ((state_r == ST_IDLE) && idle_seen_r && !parked_ok_f(bus_in)) begin
                park_err_r <= 1'b1;
            end else begin
                park_err_r <= park_err_r;
            end
        end
    end

    assign gnt      = gnt_r;
    assign bus_oe   = bus_oe_r;
    assign owner    = owner_r;
    assign busy     = busy_r;
    assign preempt  = preempt_r;
    assign park_err = park_err_r;

endmodule

// Run-time invariants on the arbiter outputs, bound alongside the arbiter in simulation.
module bus_arbiter_checker #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic [NREQ-1:0] gnt,
    input logic            bus_oe,
    input logic            preempt
);
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_oe_matches:  assert property (@(posedge clk) disable iff (!rst_n) bus_oe == (|gnt));
    a_pre_release: assert property (@(posedge clk) disable iff (!rst_n) preempt |-> (gnt == {NREQ{1'b0}}));
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scenarios plus randomized traffic for bus_arbiter, checked cycle by cycle
// against a rule-level model of ownership, tenure and release gaps.
module tb_bus_arbiter;
    localparam int NREQ       = 4;
    localparam int WIDTH      = 9;
    localparam int MAX_HOLD   = 8;
    localparam int TURNAROUND = 1;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic             bus_oe;
    logic [1:0]       owner;
    logic             busy;
    logic             preempt;
    logic [WIDTH-1:0] bus_in;
    logic             park_err;

    always #5 clk = ~clk;

    bus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .bus_oe(bus_oe), .owner(owner),
        .busy(busy), .preempt(preempt), .bus_in(bus_in), .park_err(park_err)
    );

    bus_arbiter_checker #(.NREQ(NREQ)) chk_u (
        .clk(clk), .rst_n(rst_n), .gnt(gnt), .bus_oe(bus_oe), .preempt(preempt)
    );

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who holds the bus, for how long, how much release gap remains.
    int m_own;          // current owner, -1 when nobody holds the bus
    int m_tenure;       // consecutive cycles the current owner has held the bus
    int m_gap;          // released cycles still to go before arbitration resumes
    int m_last;         // last granted requester (round-robin reference)
    int m_owner_out;    // value the owner port should show
    int m_idle_before;  // consecutive fully idle cycles preceding the current one
    bit m_pre;
    bit m_park;

    task automatic model_edge(input logic [NREQ-1:0] r, input logic rst, input logic [WIDTH-1:0] b);
        bit cur_idle;
        bit found;
        logic [NREQ-1:0] mine;
        if (!rst) begin
            m_own = -1; m_tenure = 0; m_gap = 0; m_last = NREQ - 1;
            m_owner_out = 0; m_idle_before = 0; m_pre = 0; m_park = 0;
            return;
        end
        cur_idle = (m_own < 0) && (m_gap == 0);
        if (cur_idle && m_idle_before >= 1 && b != ONES) m_park = 1;
        m_idle_before = cur_idle ? m_idle_before + 1 : 0;
        m_pre = 0;
        if (m_own >= 0) begin
            mine = NREQ'(1) << m_own;
            if (!r[m_own]) begin
                m_own = -1; m_gap = TURNAROUND;
            end else if ((r & ~mine) != '0 && m_tenure >= MAX_HOLD) begin
                m_own = -1; m_gap = TURNAROUND; m_pre = 1;
            end else begin
                m_tenure++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && r[(m_last + k) % NREQ]) begin
                    found = 1;
                    m_own = (m_last + k) % NREQ;
                end
            end
            if (found) begin
                m_last = m_own; m_owner_out = m_own; m_tenure = 1;
            end
        end
    endtask

    function automatic logic [NREQ-1:0] exp_gnt();
        return (m_own >= 0) ? (NREQ'(1) << m_own) : '0;
    endfunction

    // Bus value for the coming cycle: owner data while granted, pullup otherwise,
    // with noise allowed in the unchecked first idle cycle.
    function automatic logic [WIDTH-1:0] bus_auto();
        if (m_own >= 0) return WIDTH'($urandom);
        else if (m_gap == 0 && m_idle_before == 0) return WIDTH'($urandom);
        else return ONES;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt",      32'(gnt),      32'(exp_gnt()));
        chk("bus_oe",   32'(bus_oe),   32'(m_own >= 0));
        chk("owner",    32'(owner),    32'(m_owner_out));
        chk("busy",     32'(busy),     32'((m_own >= 0) || (m_gap > 0)));
        chk("preempt",  32'(preempt),  32'(m_pre));
        chk("park_err", 32'(park_err), 32'(m_park));
    endtask

    task automatic tick(input logic [NREQ-1:0] r, input logic rst, input logic [WIDTH-1:0] b);
        req = r; rst_n = rst; bus_in = b;
        @(posedge clk);
        model_edge(r, rst, b);
        #1;
        n_vec++;
        check_all();
    endtask

    initial begin
        logic [NREQ-1:0] cur;
        logic rst;
        int q_own[$];
        int n_pre;
        bit prev_g;
        int exp_seq[5] = '{0, 1, 2, 3, 0};

        req = '0; rst_n = 1'b0; bus_in = ONES;

        // Reset state
        tick(4'b0000, 1'b0, ONES);
        tick(4'b0000, 1'b0, ONES);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_park", 32'(park_err), 32'd0);

        // Single requester: grant one cycle after request, release gap afterwards
        for (int c = 1; c <= 5; c++) begin
            tick(4'b0001, 1'b1, bus_auto());
            if (c == 1) chk("single_c1_gnt", 32'(gnt), 32'h1);
        end
        tick(4'b0000, 1'b1, bus_auto());
        chk("single_c6_gnt", 32'(gnt), 32'd0);
        chk("single_c6_busy", 32'(busy), 32'd1);
        tick(4'b0000, 1'b1, bus_auto());
        tick(4'b0000, 1'b1, bus_auto());
        chk("single_c8_busy", 32'(busy), 32'd0);

        // All requesting: rotation 0,1,2,3,0 with a preempt per handover
        tick(4'b0000, 1'b0, ONES);
        q_own.delete(); n_pre = 0; prev_g = 0;
        for (int c = 0; c < 48; c++) begin
            tick(4'b1111, 1'b1, bus_auto());
            if (gnt != '0 && !prev_g) q_own.push_back(int'(owner));
            prev_g = (gnt != '0);
            if (preempt) n_pre++;
        end
        chk("rot_grants", 32'(q_own.size()), 32'd5);
        if (q_own.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("rot_owner", 32'(q_own[i]), 32'(exp_seq[i]));
        end
        chk("rot_preempts", 32'(n_pre), 32'd4);

        // Fairness: owner 2 releases while 0 and 2 request, 0 must follow
        tick(4'b0000, 1'b0, ONES);
        tick(4'b0100, 1'b1, bus_auto());
        chk("rr_first", 32'(gnt), 32'h4);
        for (int c = 0; c < 3; c++) tick(4'b0101, 1'b1, bus_auto());
        tick(4'b0001, 1'b1, bus_auto());
        tick(4'b0101, 1'b1, bus_auto());
        tick(4'b0101, 1'b1, bus_auto());
        chk("rr_next_gnt", 32'(gnt), 32'h1);

        // Lone owner keeps the bus indefinitely
        tick(4'b0000, 1'b0, ONES);
        n_pre = 0;
        for (int c = 0; c < 50; c++) begin
            tick(4'b0010, 1'b1, bus_auto());
            if (preempt) n_pre++;
        end
        chk("lone_gnt", 32'(gnt), 32'h2);
        chk("lone_preempts", 32'(n_pre), 32'd0);

        // Owner drops exactly at the hold limit with another pending: plain release
        tick(4'b0000, 1'b0, ONES);
        for (int c = 0; c < 8; c++) tick(4'b0011, 1'b1, bus_auto());
        chk("limit_still_owner", 32'(gnt), 32'h1);
        tick(4'b0010, 1'b1, bus_auto());
        chk("limit_drop_gnt", 32'(gnt), 32'd0);
        chk("limit_drop_preempt", 32'(preempt), 32'd0);
        chk("limit_drop_busy", 32'(busy), 32'd1);

        // Reset in the middle of a grant, then a non-parked bus while idle
        tick(4'b0000, 1'b0, ONES);
        for (int c = 0; c < 3; c++) tick(4'b0100, 1'b1, bus_auto());
        tick(4'b0100, 1'b0, ONES);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_owner", 32'(owner), 32'd0);
        chk("midrst_oe", 32'(bus_oe), 32'd0);
        tick(4'b0000, 1'b1, 9'h1FE);
        chk("park_first_idle", 32'(park_err), 32'd0);
        tick(4'b0000, 1'b1, 9'h1FE);
        for (int c = 0; c < 3; c++) tick(4'b0000, 1'b1, ONES);
        chk("park_sticky", 32'(park_err), 32'd1);
        tick(4'b1010, 1'b1, ONES);
        chk("rr_after_reset", 32'(gnt), 32'h2);

        // Randomized traffic: level requests, only the owner lets go, rare resets
        tick(4'b0000, 1'b0, ONES);
        cur = '0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!cur[i] && $urandom_range(0, 7) == 0) cur[i] = 1'b1;
            end
            if (m_own >= 0 && cur[m_own] && $urandom_range(0, 9) == 0) cur[m_own] = 1'b0;
            rst = ($urandom_range(0, 399) != 0);
            tick(cur, rst, bus_auto());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
